hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/div_stall_fsm.sv | 68 ++++++
 rtl/hazard_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forward-select
// encodings, the divide-stall FSM state type, the default divide latency,
// and the helper functions that compute forwarding selects.
package mips_pkg;

  // Forward-select encodings for the E-stage ALU operand multiplexers
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Default divider latency in cycles (legal range 2..63)
  localparam int DIV_CYCLES_DEFAULT = 32;

  // Width of the divide down-counter
  localparam int DIV_CNT_W = 6;

  // Divide-stall FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // E-stage forward select: M wins over W, and register 0 is never forwarded
  function automatic logic [1:0] fwd_sel_e(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] dst_m,
    input logic       wr_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if ((src != 5'd0) && wr_m && (src == dst_m)) begin
      sel = FWD_MEM;
    end else if ((src != 5'd0) && wr_w && (src == dst_w)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // D-stage comparator forward from M: only a real register write in M counts
  function automatic logic fwd_sel_d(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] dst_m
  );
    return (src != 5'd0) && wr_m && (src == dst_m);
  endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divide stall controller. Holds the E stage while a divide is
// in progress and pulses divreadyE for one cycle when the result is ready.
// Only built when DIV_STALL_EN is defined; otherwise the top treats the
// divide as single-cycle and this module is not compiled.
`ifdef DIV_STALL_EN
module div_stall_fsm
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic divE,
  output logic divstall,
  output logic divreadyE
);

  // The IDLE cycle and the final BUSY cycle both stall, so the counter
  // starts two below the latency to give exactly DIV_CYCLES stall cycles.
  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 2);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q,   cnt_d;

  // State and counter registers; reset abandons any divide in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and stall/ready outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divreadyE = 1'b0;
    divstall  = divE && (state_q != DONE);
    case (state_q)
      IDLE: begin
        if (divE) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        divreadyE = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding for the D and E stages, HI/LO
// forwarding, load-use and branch stalls, and the divide stall.
// Optional feature macro: DIV_STALL_EN -- when defined, a multi-cycle divide
// FSM holds the pipeline; when undefined, divides complete in one cycle.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       hilowriteM,
  input  logic       hilotoregE,
  input  logic       divE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardhiloE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       divreadyE
);

  logic lwstall;
  logic branchstall;
  logic divstall;

  // Forwarding selects for the ALU operands, branch comparator and HI/LO
  always_comb begin
    forwardAE    = fwd_sel_e(rsE, regwriteM, writeregM, regwriteW, writeregW);
    forwardBE    = fwd_sel_e(rtE, regwriteM, writeregM, regwriteW, writeregW);
    forwardAD    = fwd_sel_d(rsD, regwriteM, writeregM);
    forwardBD    = fwd_sel_d(rtD, regwriteM, writeregM);
    forwardhiloE = hilowriteM & hilotoregE;
  end

  // Load-use and branch hazards, merged with the divide stall
  always_comb begin
    lwstall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
    branchstall = branchD &
                  ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                   (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
    stallF      = divstall | lwstall | branchstall;
    stallD      = divstall | lwstall | branchstall;
    stallE      = divstall;
    flushM      = divstall;
    flushE      = (lwstall | branchstall) & ~divstall;
  end

`ifdef DIV_STALL_EN
  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_stall_fsm (
    .clk       (clk),
    .rst       (rst),
    .divE      (divE),
    .divstall  (divstall),
    .divreadyE (divreadyE)
  );
`else
  // Single-cycle divide: no state, the result is ready as soon as it is issued
  logic unused_div;
  assign unused_div = clk ^ rst ^ 1'(DIV_CYCLES);
  assign divstall   = 1'b0;
  assign divreadyE  = divE;
`endif

endmodule
